// File: rtl/shift_pipe.sv
// shift_pipe: two-stage pipelined shift unit (SRL, SLL, SRA, optional ROR).
// Left shifts are built by bit-reversing the operand, shifting right, and
// reversing the result back, so only one right shifter exists.
// Optional feature macro: SHIFT_ROTATE_EN enables op 2'b11 as rotate right;
// when undefined, op 2'b11 behaves exactly like SRL and no rotate logic exists.
// Handshake: valid/ready on both sides; stage A feeds stage B, out_data = stage B.

module shift_pipe #(
    parameter  int WIDTH = 32,
    localparam int AMTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    // Stage A state
    logic             a_valid_r;
    logic [WIDTH-1:0] a_data_r;
    logic [AMTW-1:0]  a_amt_r;
    logic [1:0]       a_op_r;
    logic             a_sign_r;

    // Stage B state
    logic             b_valid_r;
    logic [WIDTH-1:0] b_data_r;

    // Handshake and datapath nets
    logic             b_ready_s;
    logic             a_fire_s;
    logic             b_load_s;
    logic             in_is_sll_s;
    logic             in_sign_s;
    logic             a_is_sll_s;
    logic [WIDTH-1:0] in_sel_s;
    logic [WIDTH:0]   shr_ext_s;
    logic [WIDTH-1:0] shr_res_s;
    logic [WIDTH-1:0] core_res_s;
    logic [WIDTH-1:0] b_next_s;

    // Ready chain: stage B frees when empty or draining; stage A frees when
    // empty or able to move into B. Held low while reset is asserted.
    assign b_ready_s = !b_valid_r || out_ready;
    assign in_ready  = rst_n && (!a_valid_r || b_ready_s);
    assign a_fire_s  = in_valid && in_ready;
    assign b_load_s  = a_valid_r && b_ready_s;

    assign in_is_sll_s = (in_op == OP_SLL);
    assign in_sign_s   = (in_op == OP_SRA) ? in_data[WIDTH-1] : 1'b0;
    assign a_is_sll_s  = (a_op_r == OP_SLL);

    // Bit reversal (bit i <-> bit WIDTH-1-i) as per-bit 2:1 selects, once on
    // the way into stage A and once on the way into stage B.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_rev
            assign in_sel_s[i] = in_is_sll_s ? in_data[WIDTH-1-i] : in_data[i];
            assign b_next_s[i] = a_is_sll_s ? core_res_s[WIDTH-1-i] : core_res_s[i];
        end
    endgenerate

    // Single right shifter: prepending the fill bit and shifting arithmetically
    // makes vacated positions take a_sign (0 for SRL/SLL, msb for SRA).
    always_comb begin
        shr_ext_s = $signed({a_sign_r, a_data_r}) >>> a_amt_r;
        shr_res_s = shr_ext_s[WIDTH-1:0];
    end

`ifdef SHIFT_ROTATE_EN
    logic [2*WIDTH-1:0] rot_ext_s;

    // Rotate right: the low half of {x,x} >> n equals (x >> n) | (x << (WIDTH-n)),
    // and n = 0 naturally yields x.
    always_comb begin
        rot_ext_s = {a_data_r, a_data_r} >> a_amt_r;
        if (a_op_r == OP_ROR) begin
            core_res_s = rot_ext_s[WIDTH-1:0];
        end else begin
            core_res_s = shr_res_s;
        end
    end
`else
    assign core_res_s = shr_res_s;
`endif

    // Stage A register: captures operand (pre-reversed for SLL), amount, op, fill bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_r <= 1'b0;
            a_data_r  <= '0;
            a_amt_r   <= '0;
            a_op_r    <= OP_SRL;
            a_sign_r  <= 1'b0;
        end else begin
            if (a_fire_s) begin
                a_valid_r <= 1'b1;
                a_data_r  <= in_sel_s;
                a_amt_r   <= in_amt;
                a_op_r    <= in_op;
                a_sign_r  <= in_sign_s;
            end else if (b_load_s) begin
                a_valid_r <= 1'b0;
            end
        end
    end

    // Stage B register: captures the finished result; data only changes on a load
    // so out_data holds while stalled and after the pipeline drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_valid_r <= 1'b0;
            b_data_r  <= '0;
        end else begin
            if (b_ready_s) begin
                b_valid_r <= a_valid_r;
            end
            if (b_load_s) begin
                b_data_r <= b_next_s;
            end
        end
    end

    assign out_valid = b_valid_r;
    assign out_data  = b_data_r;

endmodule
